// File: rtl/bram_pkg.sv
// Shared constants, sizing helpers and the clear-sweep state type for the
// two-port byte-enable block RAM.
package bram_pkg;

  localparam int WR_READ_FIRST  = 0;
  localparam int WR_WRITE_FIRST = 1;

  function automatic int BYTES(input int data);
    return data / 8;
  endfunction

  // One even-parity bit per byte lane.
  function automatic int PAR_W(input int data);
    return data / 8;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/bram_2p_port.sv
// Per-port read path: same-port write-first merge, optional output register,
// valid pipeline and (with BRAM2P_PARITY_EN) byte parity check.
module bram_2p_port
  import bram_pkg::*;
#(
  parameter int DATA     = 32,
  parameter int READ_LAT = 1,
  parameter int WRMODE   = WR_READ_FIRST
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc,
  input  logic [BYTES(DATA)-1:0] we,
  input  logic [DATA-1:0]        wdata,
  input  logic [DATA-1:0]        mem_q,
`ifdef BRAM2P_PARITY_EN
  input  logic [PAR_W(DATA)-1:0] par_q,
  output logic                   perr,
`endif
  output logic [DATA-1:0]        rdata,
  output logic                   valid
);

  localparam int   NB = BYTES(DATA);
  localparam logic WF = (WRMODE == WR_WRITE_FIRST);

  logic            v1;
  logic [NB-1:0]   we_q;
  logic [DATA-1:0] wdata_q;
  logic [DATA-1:0] merged;

  // Write info is captured only on an access so rdata holds while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= 1'b0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      v1 <= acc;
      if (acc) begin
        we_q    <= we;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    merged = mem_q;
    for (int i = 0; i < NB; i++) begin
      if (WF && we_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

`ifdef BRAM2P_PARITY_EN
  logic flag1;
  logic pb;

  always_comb begin
    flag1 = 1'b0;
    pb    = 1'b0;
    for (int i = 0; i < NB; i++) begin
      pb    = (WF && we_q[i]) ? ^wdata_q[8*i +: 8] : par_q[i];
      flag1 = flag1 | (^merged[8*i +: 8] ^ pb);
    end
  end
`endif

  generate
    if (READ_LAT == 2) begin : g_lat2
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rdata <= '0;
          valid <= 1'b0;
`ifdef BRAM2P_PARITY_EN
          perr  <= 1'b0;
`endif
        end else begin
          valid <= v1;
`ifdef BRAM2P_PARITY_EN
          perr  <= v1 & flag1;
`endif
          if (v1) rdata <= merged;
        end
      end
    end else begin : g_lat1
      assign rdata = merged;
      assign valid = v1;
`ifdef BRAM2P_PARITY_EN
      assign perr  = v1 & flag1;
`endif
    end
  endgenerate

endmodule

// File: rtl/bram_2psync_be.sv
// Single-clock true dual-port RAM with byte enables, 1/2-cycle latency and
// post-reset clear sweep. Optional byte parity: define BRAM2P_PARITY_EN.
module bram_2psync_be
  import bram_pkg::*;
#(
  parameter int DATA           = 32,
  parameter int ADDR           = 10,
  parameter int READ_LAT       = 1,
  parameter int WRMODE         = WR_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   init_busy,
  input  logic                   a_en,
  input  logic [BYTES(DATA)-1:0] a_we,
  input  logic [ADDR-1:0]        a_addr,
  input  logic [DATA-1:0]        a_write,
  output logic [DATA-1:0]        a_read,
  output logic                   a_valid,
  input  logic                   b_en,
  input  logic [BYTES(DATA)-1:0] b_we,
  input  logic [ADDR-1:0]        b_addr,
  input  logic [DATA-1:0]        b_write,
  output logic [DATA-1:0]        b_read,
  output logic                   b_valid
`ifdef BRAM2P_PARITY_EN
  ,
  output logic                   a_perr,
  output logic                   b_perr
`endif
);

  localparam int NB    = BYTES(DATA);
  localparam int DEPTH = 1 << ADDR;

  logic [DATA-1:0] mem [DEPTH];
`ifdef BRAM2P_PARITY_EN
  logic [PAR_W(DATA)-1:0] par_mem [DEPTH];
  logic [PAR_W(DATA)-1:0] a_pq, b_pq;
`endif

  clr_state_t      clr_state;
  logic [ADDR-1:0] clr_cnt;
  logic            clr_we;
  logic            a_acc, b_acc;
  logic [DATA-1:0] a_q, b_q;

  generate
    if (CLEAR_ON_RESET != 0) begin : g_clr
      clr_state_t      state_nxt;
      logic [ADDR-1:0] cnt_nxt;

      // Reset parks the FSM in CLEAR so init_busy is high from assertion.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          clr_state <= CLEAR;
          clr_cnt   <= '0;
        end else begin
          clr_state <= state_nxt;
          clr_cnt   <= cnt_nxt;
        end
      end

      always_comb begin
        state_nxt = clr_state;
        cnt_nxt   = clr_cnt;
        case (clr_state)
          IDLE: ;
          CLEAR: begin
            cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == '1) state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end else begin : g_noclr
      assign clr_state = IDLE;
      assign clr_cnt   = '0;
    end
  endgenerate

  assign init_busy = (clr_state == CLEAR);
  assign clr_we    = (clr_state == CLEAR) && !reset;
  assign a_acc     = a_en && !init_busy;
  assign b_acc     = b_en && !init_busy;

  // B lanes are written before A lanes so A wins overlapping bytes.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_cnt] <= '0;
`ifdef BRAM2P_PARITY_EN
      par_mem[clr_cnt] <= '0;
`endif
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (b_acc && b_we[i]) begin
          mem[b_addr][8*i +: 8] <= b_write[8*i +: 8];
`ifdef BRAM2P_PARITY_EN
          par_mem[b_addr][i] <= ^b_write[8*i +: 8];
`endif
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (a_acc && a_we[i]) begin
          mem[a_addr][8*i +: 8] <= a_write[8*i +: 8];
`ifdef BRAM2P_PARITY_EN
          par_mem[a_addr][i] <= ^a_write[8*i +: 8];
`endif
        end
      end
    end
  end

  // Array read register always returns pre-write contents; cross-port reads
  // are therefore read-first regardless of WRMODE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
`ifdef BRAM2P_PARITY_EN
      a_pq <= '0;
      b_pq <= '0;
`endif
    end else begin
      if (a_acc) begin
        a_q <= mem[a_addr];
`ifdef BRAM2P_PARITY_EN
        a_pq <= par_mem[a_addr];
`endif
      end
      if (b_acc) begin
        b_q <= mem[b_addr];
`ifdef BRAM2P_PARITY_EN
        b_pq <= par_mem[b_addr];
`endif
      end
    end
  end

  // x_valid is a one-cycle strobe READ_LAT cycles after each access; there is
  // no backpressure, the consumer must take x_read while x_valid is high.
  bram_2p_port #(
    .DATA(DATA), .READ_LAT(READ_LAT), .WRMODE(WRMODE)
  ) u_port_a (
    .clk   (clk),
    .reset (reset),
    .acc   (a_acc),
    .we    (a_we),
    .wdata (a_write),
    .mem_q (a_q),
`ifdef BRAM2P_PARITY_EN
    .par_q (a_pq),
    .perr  (a_perr),
`endif
    .rdata (a_read),
    .valid (a_valid)
  );

  bram_2p_port #(
    .DATA(DATA), .READ_LAT(READ_LAT), .WRMODE(WRMODE)
  ) u_port_b (
    .clk   (clk),
    .reset (reset),
    .acc   (b_acc),
    .we    (b_we),
    .wdata (b_write),
    .mem_q (b_q),
`ifdef BRAM2P_PARITY_EN
    .par_q (b_pq),
    .perr  (b_perr),
`endif
    .rdata (b_read),
    .valid (b_valid)
  );

endmodule

// File: tb/tb_bram_2psync_be.sv
// Bench for bram_2psync_be: two instances (read-first/latency 1 and
// write-first/latency 2) driven by the same stimulus, checked by a model.
module tb_bram_2psync_be;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy0, busy1;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we, a_addr, b_addr;
  logic [31:0] a_write, b_write;
  logic [31:0] a_read0, b_read0, a_read1, b_read1;
  logic        a_valid0, b_valid0, a_valid1, b_valid1;
`ifdef BRAM2P_PARITY_EN
  logic        a_perr0, b_perr0, a_perr1, b_perr1;
  logic [3:0]  mbad [DEPTH];
`endif

  always #5 clk = ~clk;

  bram_2psync_be #(
    .DATA(32), .ADDR(4), .READ_LAT(1), .WRMODE(0), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .init_busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_write(a_write),
    .a_read(a_read0), .a_valid(a_valid0),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_write(b_write),
    .b_read(b_read0), .b_valid(b_valid0)
`ifdef BRAM2P_PARITY_EN
    , .a_perr(a_perr0), .b_perr(b_perr0)
`endif
  );

  bram_2psync_be #(
    .DATA(32), .ADDR(4), .READ_LAT(2), .WRMODE(1), .CLEAR_ON_RESET(1)
  ) dut2 (
    .clk(clk), .reset(reset), .init_busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_write(a_write),
    .a_read(a_read1), .a_valid(a_valid1),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_write(b_write),
    .b_read(b_read1), .b_valid(b_valid1)
`ifdef BRAM2P_PARITY_EN
    , .a_perr(a_perr1), .b_perr(b_perr1)
`endif
  );

  typedef struct {
    logic [31:0] d;
    int          c;
    logic        p;
  } exp_t;

  // Streams: 0 = dut A, 1 = dut B, 2 = dut2 A, 3 = dut2 B.
  exp_t        exp_q [4][$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_d [4];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          model_busy = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lat_of(input int s);
    return (s < 2) ? 1 : 2;
  endfunction

  function automatic bit wf_of(input int s);
    return (s >= 2);
  endfunction

  task automatic model_issue();
    exp_t        e;
    logic [3:0]  we, ad;
    logic [31:0] wd;
    bit          en;
    if (model_busy) return;
    for (int s = 0; s < 4; s++) begin
      en = (s % 2 == 0) ? a_en : b_en;
      we = (s % 2 == 0) ? a_we : b_we;
      ad = (s % 2 == 0) ? a_addr : b_addr;
      wd = (s % 2 == 0) ? a_write : b_write;
      if (en) begin
        e.d = mdl[ad];
        e.p = 1'b0;
        e.c = cyc;
        for (int i = 0; i < 4; i++)
          if (wf_of(s) && we[i]) e.d[8*i +: 8] = wd[8*i +: 8];
`ifdef BRAM2P_PARITY_EN
        e.p = |(mbad[ad] & ~(wf_of(s) ? we : 4'b0));
`endif
        exp_q[s].push_back(e);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (b_en && b_we[i]) begin
        mdl[b_addr][8*i +: 8] = b_write[8*i +: 8];
`ifdef BRAM2P_PARITY_EN
        mbad[b_addr][i] = 1'b0;
`endif
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (a_en && a_we[i]) begin
        mdl[a_addr][8*i +: 8] = a_write[8*i +: 8];
`ifdef BRAM2P_PARITY_EN
        mbad[a_addr][i] = 1'b0;
`endif
      end
    end
  endtask

  task automatic tick();
    logic        vld [4];
    logic [31:0] rd [4];
    bit          ev;
    exp_t        e;
`ifdef BRAM2P_PARITY_EN
    logic        pe [4];
`endif
    model_issue();
    @(posedge clk);
    #1;
    cyc++;
    vld[0] = a_valid0; vld[1] = b_valid0; vld[2] = a_valid1; vld[3] = b_valid1;
    rd[0]  = a_read0;  rd[1]  = b_read0;  rd[2]  = a_read1;  rd[3]  = b_read1;
`ifdef BRAM2P_PARITY_EN
    pe[0] = a_perr0; pe[1] = b_perr0; pe[2] = a_perr1; pe[3] = b_perr1;
`endif
    for (int s = 0; s < 4; s++) begin
      ev = (exp_q[s].size() > 0) && (cyc - exp_q[s][0].c == lat_of(s));
      check($sformatf("valid_s%0d", s), 32'(vld[s]), 32'(ev));
      if (ev) begin
        e = exp_q[s].pop_front();
        last_d[s] = e.d;
        if (vld[s]) begin
          check($sformatf("rdata_s%0d", s), rd[s], e.d);
`ifdef BRAM2P_PARITY_EN
          check($sformatf("perr_s%0d", s), 32'(pe[s]), 32'(e.p));
`endif
        end
      end
    end
  endtask

  task automatic idle();
    a_en = 1'b0; b_en = 1'b0; a_we = '0; b_we = '0;
  endtask

  task automatic acc(input logic ae, input logic [3:0] awe, input logic [3:0] aad,
                     input logic [31:0] awd, input logic be, input logic [3:0] bwe,
                     input logic [3:0] bad, input logic [31:0] bwd);
    a_en = ae; a_we = awe; a_addr = aad; a_write = awd;
    b_en = be; b_we = bwe; b_addr = bad; b_write = bwd;
    tick();
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic reset_and_sweep(input int abort_at);
    int n0, n1;
    drain();
    model_busy = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy0", 32'(busy0), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd1);
    check("rst_a_read0", a_read0, 32'h0);
    check("rst_b_read0", b_read0, 32'h0);
    check("rst_a_read1", a_read1, 32'h0);
    check("rst_b_read1", b_read1, 32'h0);
    reset = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      // Writes while busy must be dropped; targets are already swept.
      if (k < 10) acc(1'b1, 4'hF, 4'd0, 32'hFFFF_FFFF, 1'b1, 4'hF, 4'(k >> 1), 32'hA5A5_A5A5);
      else begin
        idle();
        tick();
      end
    end
    check("busy_cycles0", 32'(n0), 32'(DEPTH));
    check("busy_cycles1", 32'(n1), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      mdl[a] = '0;
`ifdef BRAM2P_PARITY_EN
      mbad[a] = '0;
`endif
    end
    model_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pending;
    reset = 1'b1;
    a_addr = '0; b_addr = '0; a_write = '0; b_write = '0;
    idle();
    for (int s = 0; s < 4; s++) last_d[s] = '0;

    reset_and_sweep(0);
    for (int k = 0; k < DEPTH; k++)
      acc(1'b1, 4'h0, 4'(k), 32'h0, 1'b1, 4'h0, 4'(15 - k), 32'h0);

    // Partial byte write over a full word, then a shared read of it.
    acc(1'b1, 4'hF, 4'd3, 32'h1122_3344, 1'b0, 4'h0, 4'd0, 32'h0);
    acc(1'b1, 4'b0101, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'h0, 4'd0, 32'h0);
    acc(1'b1, 4'h0, 4'd3, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    drain();
    check("hold_a0", a_read0, last_d[0]);
    check("hold_a1", a_read1, last_d[2]);
    check("hold_b1", b_read1, last_d[3]);

    // Same-port read during full write: old data vs merged data.
    acc(1'b1, 4'hF, 4'd5, 32'hCAFE_F00D, 1'b0, 4'h0, 4'd0, 32'h0);
    acc(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);

    // Cross-port collisions on address 7.
    acc(1'b1, 4'b0011, 4'd7, 32'hAAAA_AAAA, 1'b1, 4'b0110, 4'd7, 32'h5555_5555);
    acc(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);
    acc(1'b1, 4'hF, 4'd7, 32'h1234_5678, 1'b1, 4'h0, 4'd7, 32'h0);
    acc(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'hF, 4'd7, 32'h9ABC_DEF0);
    acc(1'b1, 4'hC, 4'd7, 32'h0F0F_0F0F, 1'b1, 4'h6, 4'd7, 32'hF0F0_F0F0);
    acc(1'b1, 4'h0, 4'd7, 32'h0, 1'b1, 4'h0, 4'd7, 32'h0);

    // Eight back-to-back reads on both ports.
    for (int k = 0; k < 8; k++)
      acc(1'b1, 4'h0, 4'(k), 32'h0, 1'b1, 4'h0, 4'(15 - k), 32'h0);
    drain();

    for (int k = 0; k < 300; k++)
      acc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
          32'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 32'($urandom));
    drain();

    // Reset mid-sweep at count 9; sweep must restart and run in full.
    reset_and_sweep(9);
    for (int k = 0; k < DEPTH; k++)
      acc(1'b1, 4'h0, 4'(k), 32'h0, 1'b1, 4'h0, 4'(k ^ 5), 32'h0);

`ifdef BRAM2P_PARITY_EN
    drain();
    dut.par_mem[2][0]  = ~dut.par_mem[2][0];
    dut2.par_mem[2][0] = ~dut2.par_mem[2][0];
    mbad[2][0] = 1'b1;
    acc(1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'h0, 4'd2, 32'h0);
    acc(1'b1, 4'hF, 4'd2, 32'h0102_0304, 1'b0, 4'h0, 4'd0, 32'h0);
    acc(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
`endif
    drain();

    pending = 0;
    for (int s = 0; s < 4; s++) pending += exp_q[s].size();
    check("pending_results", 32'(pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_2psync_be.md
Name: bram_2psync_be

Overview:
Parametrised successor to the fixed 8x128 synchronous dual-port RAM wrapper. Two symmetric read/write ports share one clock, with these additions:
- per-byte write enables
- selectable same-port read-during-write mode
- 1- or 2-cycle read latency with per-port valid strobes
- deterministic cross-port collision rules
- optional post-reset clear sequencer

It is used for CPU/DMA shared buffers and register-file style memories on the ECP5 build.

Parameters:
DATA, 32, data width in bits; must be a multiple of 8.
ADDR, 10, address width; depth = 2**ADDR words.
READ_LAT, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register).
WRMODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (merged new data).
CLEAR_ON_RESET, 1, 1 = zero the whole memory after reset via the sweep sequencer.

Ports:
clk  in  1  single clock for both ports
reset  in  1  asynchronous, active-high reset
init_busy  out  1  high while the clear sweep runs
a_en  in  1  port A access enable
a_we  in  DATA/8  port A byte write enables (bit i -> a_write[8i+7:8i])
a_addr  in  ADDR  port A word address
a_write  in  DATA  port A write data
a_read  out  DATA  port A read data
a_valid  out  1  a_read holds data of the access issued READ_LAT cycles earlier
b_en, b_we, b_addr, b_write, b_read, b_valid: identical to port A, for port B

Behaviour:
Reset:
- clk and reset are the only clock/reset; reset is asynchronous and active-high.
- Reset clears a_read, b_read, a_valid, b_valid and all pipeline registers to 0.
- Memory contents are untouched by reset itself.
- With CLEAR_ON_RESET=1, init_busy=1 from reset assertion.

Clear sweep (CLEAR_ON_RESET=1):
- FSM states: IDLE, CLEAR.
- On reset release, FSM enters CLEAR with a counter at 0. Each cycle it writes all-zero to mem[counter] and increments.
- After writing address 2**ADDR-1 it goes to IDLE; init_busy falls in the same cycle the last write occurs. The sweep takes exactly 2**ADDR cycles.
- While init_busy=1, port accesses are ignored: no writes, and valids stay 0.
- Reset asserted mid-sweep aborts it; the counter restarts from 0 on release.
- With CLEAR_ON_RESET=0, init_busy is tied to 0 and the FSM is absent.

Access:
- An access occurs when x_en=1 and init_busy=0.
- Each byte lane with x_we[i]=1 is written at the rising edge.
- Every access is also a read; x_valid rises READ_LAT cycles after the access cycle, for one cycle per access.
- x_en=0: x_read holds its last value and x_valid=0.

Same-port read-during-write:
- WRMODE=0: x_read returns pre-write contents.
- WRMODE=1: written lanes return new data, other lanes return old data.

Cross-port collisions (same address, same cycle):
- A writes, B reads: B gets old data (read-first), regardless of WRMODE. Same rule with A and B swapped.
- Both write: lanes enabled on A take A data; lanes enabled only on B take B data. Port A wins overlapping lanes.
- Both read: both get identical data.

Pipelining:
- Back-to-back accesses on every cycle are fully pipelined, one result per cycle per port.

Optional Feature:
Macro BRAM2P_PARITY_EN.
- Defined: one even-parity bit is stored per byte (memory width DATA + DATA/8). Outputs a_perr and b_perr (1 bit each) are added. Each flags a parity mismatch on any byte of the returned word, aligned with x_valid.
- The clear sweep writes correct parity (0).
- Undefined: no parity storage and no perr ports.

Decomposition:
Package bram_pkg contains:
- localparam functions BYTES(DATA) and PAR_W(DATA)
- WRMODE constants WR_READ_FIRST=0, WR_WRITE_FIRST=1
- FSM state typedef clr_state_t {IDLE, CLEAR}

Sub-module bram_2p_port holds one port's read-data merge, optional output register, valid pipeline and parity check. It is instantiated twice. The memory array, collision logic and clear FSM stay in the top.

Test Plan:
1. Reset, DATA=32, ADDR=4, CLEAR_ON_RESET=1 -> init_busy high for exactly 16 cycles after release; then reading addr 0..15 returns 0x00000000 with a_valid after READ_LAT.
2. Port A writes 0xDEADBEEF to addr 3 with a_we=4'b0101 over 0x11223344 -> read returns 0x11AD33EF.
3. WRMODE=1, A writes 0xCAFEF00D to addr 5 (a_we=4'hF) holding 0x0 -> a_read=0xCAFEF00D same access. With WRMODE=0 -> a_read=0x00000000.
4. A and B both write addr 7, a_we=4'b0011 data 0xAAAAAAAA, b_we=4'b0110 data 0x55555555, old 0x0 -> mem[7]=0x0055AAAA. A write + B read of addr 7 in the same cycle -> b_read = old value.
5. READ_LAT=2, reads issued on 8 consecutive cycles -> 8 consecutive valid results, each appearing 2 cycles after its address.
6. Reset asserted at sweep count 9 and released -> sweep restarts at 0 and init_busy lasts a full 2**ADDR cycles. With BRAM2P_PARITY_EN defined, a forced parity-bit flip at addr 2 -> a_perr=1, aligned with a_valid.
